fairy_wb_scheduler: RTL
=======================

Name: fairy_wb_scheduler

Overview:
- Owns the single regfile write port (we/waddr/wdata of rf2r1w) and shares it between two sources:
  - the in-order pipeline writeback;
  - long-latency results (mult/div, miss loads) that return out of order.
- Keeps a 32-entry pending-destination scoreboard and drives the decode-stage interlock (stall).
- Sits between the writeback stage, the long-latency units, the decode stage and the regfile.

Parameters:
- DEPTH, 4, return-buffer entries; power of 2, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pipe_we  in  1  pipeline writeback valid.
- pipe_waddr  in  5  pipeline destination.
- pipe_wdata  in  32  pipeline result.
- iss_valid  in  1  decode issues a long-latency op.
- iss_dest  in  5  destination of the issued op.
- iss_ready  out  1  issue accepted this cycle.
- exception_i  in  1  squashes the decode-stage issue this cycle.
- ret_valid  in  1  long-latency result valid.
- ret_dest  in  5  result destination.
- ret_data  in  32  result data.
- ret_ready  out  1  buffer can accept the result.
- dec_rs  in  5  decode source address 0.
- dec_rt  in  5  decode source address 1.
- dec_use_rs  in  1  decode reads rs.
- dec_use_rt  in  1  decode reads rt.
- dec_we  in  1  decode instruction writes a GPR through the pipeline.
- dec_waddr  in  5  its destination.
- stall_o  out  1  decode must hold.
- reg_we_o  out  1  regfile write enable.
- reg_waddr_o  out  5  regfile write address.
- reg_wdata_o  out  32  regfile write data.
- pending_o  out  32  scoreboard bits.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: scoreboard = 0, buffer empty, err_o = 0.
  - Outputs after reset: iss_ready = 1, ret_ready = 1, stall_o = 0, reg_we_o = pipe_we.
  - Reset mid-operation drops all buffered results and pending bits; no write occurs in the reset cycle from the buffer.
- Write-port mux (combinational, same cycle):
  - If pipe_we = 1, the port carries pipe_*. The pipeline has absolute priority and is never back-pressured.
  - Else, if the buffer is non-empty, the port carries the head entry and the head is popped.
  - Else reg_we_o = 0, and waddr/wdata = 0.
- Return buffer: circular FIFO, DEPTH entries of {dest, data}, write pointer, read pointer and count.
  - ret_ready = (count != DEPTH). Enqueue when ret_valid && ret_ready.
  - Minimum return-to-regfile latency is 1 cycle; no bypass.
  - When full with a simultaneous pop, ret_ready is still 0 that cycle (registered-count based).
  - Pointers wrap modulo DEPTH.
  - ret_dest = 0: accepted (ret_ready honoured) and discarded; never enqueued.
- Scoreboard pending[31:0]:
  - Set: bit iss_dest is set on an accepted issue with iss_dest != 0.
  - Clear: bit reg_waddr_o is cleared when the buffer head is written.
  - A pipeline write does not clear bits.
  - pending[0] is constant 0.
- Issue acceptance:
  - iss_ready = ~pending[iss_dest] && ~exception_i.
  - With exception_i = 1, the issue is ignored and no bit is set.
- Set/clear of the same bit in one cycle cannot occur, because issue is blocked while the bit is pending.
- Interlock: stall_o = (dec_use_rs && pending[dec_rs]) || (dec_use_rt && pending[dec_rt]) || (dec_we && pending[dec_waddr]).
  - The third term orders a pipeline WAW after the long-latency write.
  - stall_o is computed from registered pending, so a result drained in cycle N releases stall in cycle N+1.
- Error: err_o is set, and stays set until reset, when either of these occurs:
  - a result is enqueued with ret_dest != 0 and pending[ret_dest] = 0 (the write still happens);
  - pipe_we is asserted with pipe_waddr pending.

Decomposition:
- Shared package: GPR_AW = 5, XLEN = 32, REG_ZERO = 5'd0.
- One sub-module: fairy_wb_fifo, the parameterised DEPTH x 37-bit synchronous FIFO (push, pop, full, empty, count).
- Scoreboard, mux and interlock live in the top.

Test Plan:
- Issue to $8, then dec_rs = 8 with dec_use_rs = 1:
  - stall_o = 1 on every cycle until the result drains.
  - Return ret_dest = 8, ret_data = 0x1234_5678: the regfile write occurs 1 cycle later, and stall_o falls the following cycle.
- Result buffered while pipe_we = 1 to $3 for 3 consecutive cycles:
  - The pipeline writes 3 times first.
  - The buffered $8 write happens on cycle 4.
  - pending[8] stays 1 until then.
- Fill the buffer with 4 returns while pipe_we is held high:
  - ret_ready = 0 on the 5th return.
  - Release pipe_we: 4 writes in FIFO order; ret_ready = 1 again after the first pop.
- Issue to $5 while pending[5] = 1:
  - iss_ready = 0.
  - Also issue with exception_i = 1: iss_ready = 0 and pending is unchanged.
- ret_dest = 0 and an unissued ret_dest = 9:
  - $0 is never written and causes no error.
  - $9 is written and err_o becomes 1.
- Reset asserted with 2 entries buffered:
  - Next cycle: pending_o = 0, buffer empty, no buffered writes.

Source files
------------

// File: rtl/fairy_wb_scheduler_pkg.sv
// Shared widths and the return-buffer entry layout for the writeback scheduler.
package fairy_wb_scheduler_pkg;

    localparam int GPR_AW  = 5;
    localparam int XLEN    = 32;
    localparam int NUM_GPR = 2 ** GPR_AW;

    localparam logic [GPR_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [GPR_AW-1:0] dest;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/fairy_wb_scheduler_if.sv
// Long-latency result return channel (mult/div, miss loads) into the scheduler.
interface fairy_wb_scheduler_if;
    import fairy_wb_scheduler_pkg::*;

    logic              ret_valid;
    logic [GPR_AW-1:0] ret_dest;
    logic [XLEN-1:0]   ret_data;
    logic              ret_ready;

    modport master (output ret_valid, ret_dest, ret_data, input ret_ready);
    modport slave  (input ret_valid, ret_dest, ret_data, output ret_ready);

endinterface

// File: rtl/fairy_wb_fifo.sv
// Circular return buffer of {dest, data}; head is visible combinationally.
module fairy_wb_fifo
    import fairy_wb_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  wb_entry_t    push_data,
    input  logic         pop,
    output wb_entry_t    head,
    output logic         full,
    output logic         empty,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are PTR_W bits wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fairy_wb_scheduler.sv
// Regfile write-port arbiter between pipeline writeback and buffered long-latency
// results, with the pending-destination scoreboard that drives the decode interlock.
module fairy_wb_scheduler
    import fairy_wb_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               pipe_we,
    input  logic [GPR_AW-1:0]  pipe_waddr,
    input  logic [XLEN-1:0]    pipe_wdata,

    input  logic               iss_valid,
    input  logic [GPR_AW-1:0]  iss_dest,
    output logic               iss_ready,
    input  logic               exception_i,

    fairy_wb_scheduler_if.slave ret,

    input  logic [GPR_AW-1:0]  dec_rs,
    input  logic [GPR_AW-1:0]  dec_rt,
    input  logic               dec_use_rs,
    input  logic               dec_use_rt,
    input  logic               dec_we,
    input  logic [GPR_AW-1:0]  dec_waddr,
    output logic               stall_o,

    output logic               reg_we_o,
    output logic [GPR_AW-1:0]  reg_waddr_o,
    output logic [XLEN-1:0]    reg_wdata_o,

    output logic [NUM_GPR-1:0] pending_o,
    output logic               err_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [NUM_GPR-1:0] pending_q;
    logic [NUM_GPR-1:0] pending_d;
    logic               err_q;
    logic               err_d;

    wb_entry_t          buf_head;
    wb_entry_t          buf_in;
    logic               buf_full;
    logic               buf_empty;
    logic [PTR_W:0]     buf_count;
    logic               buf_push;
    logic               buf_pop;
    logic               iss_fire;

    assign ret.ret_ready = (buf_count != FULL_CNT);

    // Results to $0 are acknowledged but dropped here so they never reach the port.
    assign buf_push = ret.ret_valid & ~buf_full & (ret.ret_dest != REG_ZERO);
    assign buf_in   = '{dest: ret.ret_dest, data: ret.ret_data};
    assign buf_pop  = ~pipe_we & ~buf_empty & ~reset;

    fairy_wb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_comb begin
        reg_we_o    = 1'b0;
        reg_waddr_o = '0;
        reg_wdata_o = '0;
        if (pipe_we) begin
            reg_we_o    = 1'b1;
            reg_waddr_o = pipe_waddr;
            reg_wdata_o = pipe_wdata;
        end else if (buf_pop) begin
            reg_we_o    = 1'b1;
            reg_waddr_o = buf_head.dest;
            reg_wdata_o = buf_head.data;
        end
    end

    assign iss_ready = ~pending_q[iss_dest] & ~exception_i;
    assign iss_fire  = iss_valid & iss_ready & (iss_dest != REG_ZERO);

    // Issue is blocked while its bit is pending, so set and clear never collide.
    always_comb begin
        pending_d = pending_q;
        if (iss_fire) begin
            pending_d[iss_dest] = 1'b1;
        end
        if (buf_pop) begin
            pending_d[buf_head.dest] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    assign err_d = (buf_push & ~pending_q[ret.ret_dest])
                 | (pipe_we & pending_q[pipe_waddr]);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_q | err_d;
        end
    end

    assign stall_o = (dec_use_rs & pending_q[dec_rs])
                   | (dec_use_rt & pending_q[dec_rt])
                   | (dec_we & pending_q[dec_waddr]);

    assign pending_o = pending_q;
    assign err_o     = err_q;

endmodule
